// File: rtl/add_mul_seq_unit_if.sv
// Operand/result bundle for add_mul_seq_unit: one request channel (a, b) and one
// response channel (result_mul, result_add).
interface add_mul_seq_unit_if #(
    parameter int WIDTH = 4
);
    // Both channels use valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; valid, once raised, holds with its payload
    // until that edge, and ready is never derived combinationally from valid.
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     result_mul;
    logic [WIDTH-1:0]       result_add;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result_mul, result_add
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result_mul, result_add
    );
endinterface

// File: rtl/add_mul_seq_unit.sv
// Sequential add/multiply unit: wrap-around sum plus shift-and-add product, one
// transaction at a time. Define ADD_MUL_EARLY_TERM_EN to stop once the multiplier empties.
module add_mul_seq_unit #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    add_mul_seq_unit_if.slave   bus,
    output logic [1:0]          state_dbg
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   result_mul_q;
    logic [WIDTH-1:0]     result_add_q;

    logic [2*WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]     mplier_nxt;
    logic [CW-1:0]        cnt_nxt;
    logic                 mul_last;

    // One shift-and-add step; mul_last marks the edge that moves MUL to DONE.
    always_comb begin
        acc_nxt    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mplier_nxt = mplier_q >> 1;
        cnt_nxt    = cnt_q + CW'(1);
`ifdef ADD_MUL_EARLY_TERM_EN
        mul_last   = (cnt_nxt == CW'(WIDTH)) || (mplier_nxt == '0);
`else
        mul_last   = (cnt_nxt == CW'(WIDTH));
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = MUL;
            MUL:     if (mul_last)     state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready   = (state_q == IDLE);
        bus.out_valid  = (state_q == DONE);
        bus.result_mul = result_mul_q;
        bus.result_add = result_add_q;
        state_dbg      = state_q;
    end

    // Datapath registers; result_mul only moves on the MUL->DONE edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q      <= '0;
            mplier_q     <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            result_mul_q <= '0;
            result_add_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        mcand_q      <= {{WIDTH{1'b0}}, bus.a};
                        mplier_q     <= bus.b;
                        acc_q        <= '0;
                        cnt_q        <= '0;
                        result_add_q <= bus.a + bus.b;
                    end
                end
                MUL: begin
                    acc_q    <= acc_nxt;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_nxt;
                    cnt_q    <= cnt_nxt;
                    if (mul_last) result_mul_q <= acc_nxt;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_add_mul_seq_unit.sv
// Bench for add_mul_seq_unit at WIDTH=4 and WIDTH=8: vector table, directed
// back-pressure and reset-abort sequences, then random transactions.
module tb_add_mul_seq_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  add_mul_seq_unit_if #(.WIDTH(4)) bus4 ();
  add_mul_seq_unit_if #(.WIDTH(8)) bus8 ();
  logic [1:0] state4;
  logic [1:0] state8;

  add_mul_seq_unit #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4), .state_dbg(state4));
  add_mul_seq_unit #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8), .state_dbg(state8));

  // driver state; sel picks which instance the generic task talks to
  logic        sel;
  logic        drv_valid;
  logic [31:0] drv_a;
  logic [31:0] drv_b;
  logic        or4;
  logic        or8;

  assign bus4.in_valid  = drv_valid & ~sel;
  assign bus4.a         = drv_a[3:0];
  assign bus4.b         = drv_b[3:0];
  assign bus4.out_ready = or4;
  assign bus8.in_valid  = drv_valid & sel;
  assign bus8.a         = drv_a[7:0];
  assign bus8.b         = drv_b[7:0];
  assign bus8.out_ready = or8;

  wire        cur_in_ready  = sel ? bus8.in_ready : bus4.in_ready;
  wire        cur_out_valid = sel ? bus8.out_valid : bus4.out_valid;
  wire [63:0] cur_mul       = sel ? 64'(bus8.result_mul) : 64'(bus4.result_mul);
  wire [31:0] cur_add       = sel ? 32'(bus8.result_add) : 32'(bus4.result_add);

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] mul;
    logic [31:0] add;
    bit          w8;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Latency in cycles from the accept edge to the edge that raises out_valid.
  function automatic int ref_lat(input int w, input logic [31:0] b);
`ifdef ADD_MUL_EARLY_TERM_EN
    int hi = 0;
    for (int i = 0; i < w; i++) if (b[i]) hi = i + 1;
    return (hi < 1) ? 1 : hi;
`else
    return w;
`endif
  endfunction

  task automatic set_or(input bit v);
    if (sel) or8 = v; else or4 = v;
  endtask

  task automatic run_txn(input bit w8, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] em, input logic [31:0] ea,
                         input int stall, input string tag);
    int g;
    int lat;
    logic [63:0] qm;
    logic [63:0] qa;
    @(negedge clk);
    sel = w8; drv_a = a; drv_b = b; drv_valid = 1'b1; set_or(1'b0);
    g = 0;
    while (!cur_in_ready && g < 50) begin @(negedge clk); g++; end
    check({tag, ".in_ready"}, 64'(cur_in_ready), 64'd1);
    exp_q.push_back(em);
    exp_q.push_back(64'(ea));
    @(posedge clk);
    @(negedge clk);
    drv_valid = 1'b0;
    lat = 0;
    while (!cur_out_valid && lat < 100) begin @(posedge clk); lat++; @(negedge clk); end
    check({tag, ".latency"}, 64'(lat), 64'(ref_lat(w8 ? 8 : 4, b)));
    repeat (stall) @(negedge clk);
    check({tag, ".held_valid"}, 64'(cur_out_valid), 64'd1);
    qm = exp_q.pop_front();
    qa = exp_q.pop_front();
    check({tag, ".mul"}, cur_mul, qm);
    check({tag, ".add"}, 64'(cur_add), qa);
    set_or(1'b1);
    @(posedge clk);
    @(negedge clk);
    set_or(1'b0);
    check({tag, ".valid_drop"}, 64'(cur_out_valid), 64'd0);
    check({tag, ".ready_back"}, 64'(cur_in_ready), 64'd1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    logic [31:0] ra;
    logic [31:0] rb;
    vecs[0] = '{32'd3,   32'd5,   64'd15,    32'd8,   1'b0};
    vecs[1] = '{32'd15,  32'd15,  64'd225,   32'd14,  1'b0};
    vecs[2] = '{32'd9,   32'd0,   64'd0,     32'd9,   1'b0};
    vecs[3] = '{32'd1,   32'd1,   64'd1,     32'd2,   1'b0};
    vecs[4] = '{32'd0,   32'd15,  64'd0,     32'd15,  1'b0};
    vecs[5] = '{32'd255, 32'd255, 64'd65025, 32'd254, 1'b1};
    vecs[6] = '{32'd128, 32'd2,   64'd256,   32'd130, 1'b1};

    // reset
    rst = 1'b1; sel = 1'b0; drv_valid = 1'b0; drv_a = '0; drv_b = '0; or4 = 1'b0; or8 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.in_ready4", 64'(bus4.in_ready), 64'd1);
    check("rst.out_valid4", 64'(bus4.out_valid), 64'd0);
    check("rst.mul4", 64'(bus4.result_mul), 64'd0);
    check("rst.add4", 64'(bus4.result_add), 64'd0);
    check("rst.in_ready8", 64'(bus8.in_ready), 64'd1);
    check("rst.mul8", 64'(bus8.result_mul), 64'd0);
    rst = 1'b0;

    // vector table
    for (int i = 0; i < 7; i++)
      run_txn(vecs[i].w8, vecs[i].a, vecs[i].b, vecs[i].mul, vecs[i].add, 0, $sformatf("vec%0d", i));

    // back-pressure: a=6, b=7, consumer stalls three cycles while new operands wave about
    @(negedge clk);
    sel = 1'b0; drv_a = 32'd6; drv_b = 32'd7; drv_valid = 1'b1; or4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    drv_valid = 1'b0;
    g = 0;
    while (!bus4.out_valid && g < 100) begin @(negedge clk); g++; end
    check("bp.valid", 64'(bus4.out_valid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      drv_valid = (i % 2 == 0);
      drv_a = $urandom_range(0, 15);
      drv_b = $urandom_range(0, 15);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp.mul%0d", i), 64'(bus4.result_mul), 64'd42);
      check($sformatf("bp.add%0d", i), 64'(bus4.result_add), 64'd13);
      check($sformatf("bp.in_ready%0d", i), 64'(bus4.in_ready), 64'd0);
      check($sformatf("bp.out_valid%0d", i), 64'(bus4.out_valid), 64'd1);
    end
    drv_valid = 1'b0; or4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    or4 = 1'b0;
    check("bp.in_ready_after", 64'(bus4.in_ready), 64'd1);
    check("bp.out_valid_after", 64'(bus4.out_valid), 64'd0);
    check("bp.add_kept", 64'(bus4.result_add), 64'd13);
    @(negedge clk);
    check("bp.still_idle", 64'(state4), 64'd0);

    // reset abort two cycles into a=5, b=6
    sel = 1'b0; drv_a = 32'd5; drv_b = 32'd6; drv_valid = 1'b1; or4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drv_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort.in_ready", 64'(bus4.in_ready), 64'd1);
    check("abort.out_valid", 64'(bus4.out_valid), 64'd0);
    check("abort.mul", 64'(bus4.result_mul), 64'd0);
    check("abort.add", 64'(bus4.result_add), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("abort.no_valid%0d", i), 64'(bus4.out_valid), 64'd0);
    end
    or4 = 1'b0;
    run_txn(1'b0, 32'd2, 32'd3, 64'd6, 32'd5, 0, "post_rst");

    // random transactions against the arithmetic model
    for (int i = 0; i < 24; i++) begin
      bit w8;
      int w;
      w8 = (i % 4 == 3);
      w = w8 ? 8 : 4;
      ra = $urandom_range(0, (1 << w) - 1);
      rb = $urandom_range(0, (1 << w) - 1);
      run_txn(w8, ra, rb, 64'(ra) * 64'(rb), (ra + rb) % (32'd1 << w),
              $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
